// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: requester-side inputs and broadcast-side outputs.
interface cdb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16
);
    logic                      flush;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*TAG_W-1:0]    req_tag;
    logic [N_REQ*DATA_W-1:0]   req_value;
    logic [N_REQ-1:0]          grant;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_value;
    logic [15:0]               conflict_count;

    // Arbiter side
    modport slave (
        input  flush, req, req_tag, req_value,
        output grant, cdb_valid, cdb_tag, cdb_value, conflict_count
    );

    // Requester / write-results side
    modport master (
        output flush, req, req_tag, req_value,
        input  grant, cdb_valid, cdb_tag, cdb_value, conflict_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: combinational grant, registered
// one-cycle-later broadcast of the winner's tag/value, saturating
// contention counter.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  grant_d;
    logic [PTR_W-1:0]  gidx;
    logic              found;
    int                idx;
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_value_q;
    logic [15:0]       conflict_q;
    logic              multi_req;

    // Rotating priority search starting at ptr; only req/ptr/flush/reset feed grant.
    always_comb begin
        grant_d = '0;
        gidx    = '0;
        found   = 1'b0;
        idx     = 0;
        if (!reset && !bus.flush) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr_q) + k) % N_REQ;
                if (!found && bus.req[idx]) begin
                    found        = 1'b1;
                    grant_d[idx] = 1'b1;
                    gidx         = PTR_W'(idx);
                end
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        ptr_d = ptr_q;
        if (found)
            ptr_d = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    end

    assign multi_req = ($countones(bus.req) >= 2);

    // Broadcast register, pointer and contention counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            ptr_q       <= '0;
            conflict_q  <= '0;
        end else begin
            // found is already forced low by flush, so a flushed request never broadcasts
            cdb_valid_q <= found;
            if (found) begin
                cdb_tag_q   <= bus.req_tag[gidx*TAG_W +: TAG_W];
                cdb_value_q <= bus.req_value[gidx*DATA_W +: DATA_W];
            end
            ptr_q <= bus.flush ? '0 : ptr_d;
            if (!bus.flush && multi_req && conflict_q != 16'hFFFF)
                conflict_q <= conflict_q + 16'd1;
        end
    end

    assign bus.grant          = grant_d;
    assign bus.cdb_valid      = cdb_valid_q;
    assign bus.cdb_tag        = cdb_tag_q;
    assign bus.cdb_value      = cdb_value_q;
    assign bus.conflict_count = conflict_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a stimulus process predicts grants and
// pushes expected broadcasts; a negedge monitor pops and checks them.
module tb_cdb_arbiter;
    localparam int N = 4;
    localparam int TW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();
    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  tag;
        logic [15:0] val;
    } bc_t;

    bc_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state
    int  m_ptr = 0;
    int  m_conf = 0;
    bit  m_known = 0;
    bit  m_zero_chk = 0;
    int  m_last_g = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // First requester at or after p (circularly) that has a request.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic step(input logic rs, input logic fl, input logic [3:0] r,
                        input logic [11:0] tg, input logic [63:0] vl);
        int g;
        logic [3:0] eg;
        @(posedge clk); #1;
        if (m_known) chk("conflict_count", 64'(bus.conflict_count), 64'(m_conf));
        if (m_zero_chk) begin
            chk("tag_after_reset", 64'(bus.cdb_tag), 64'd0);
            chk("value_after_reset", 64'(bus.cdb_value), 64'd0);
        end
        reset = rs; bus.flush = fl; bus.req = r; bus.req_tag = tg; bus.req_value = vl;
        #1;
        g  = (rs || fl) ? -1 : rr_pick(r, m_ptr);
        eg = (g < 0) ? 4'b0 : (4'b1 << g);
        chk("grant", 64'(bus.grant), 64'(eg));
        m_last_g = g;
        if (rs) begin
            m_ptr = 0; m_conf = 0; m_known = 1;
        end else if (fl) begin
            m_ptr = 0;
        end else begin
            if ($countones(r) >= 2 && m_conf < 65535) m_conf++;
            if (g >= 0) begin
                exp_q.push_back('{cyc: cyc + 1, tag: tg[g*TW +: TW], val: vl[g*DW +: DW]});
                m_ptr = (g + 1) % N;
            end
        end
        m_zero_chk = rs;
    endtask

    // Monitor: every broadcast must match the head of the queue for this cycle.
    always @(negedge clk) begin
        if (bus.cdb_valid === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                chk("spurious_broadcast", 64'd1, 64'd0);
            end else begin
                chk("cdb_tag", 64'(bus.cdb_tag), 64'(exp_q[0].tag));
                chk("cdb_value", 64'(bus.cdb_value), 64'(exp_q[0].val));
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            chk("missed_broadcast", 64'(bus.cdb_valid), 64'd1);
            void'(exp_q.pop_front());
        end
    end

    bit          pend [N];
    logic [2:0]  ptag [N];
    logic [15:0] pval [N];
    int          waitc[N];

    initial begin
        logic [11:0] tg;
        logic [63:0] vl;
        logic [3:0]  r;
        logic        fl, rs;
        reset = 1'b1; bus.flush = 1'b0; bus.req = '0; bus.req_tag = '0; bus.req_value = '0;

        step(1, 0, 4'b0000, 12'h0, 64'h0);
        step(1, 0, 4'b0000, 12'h0, 64'h0);

        // Single request, then wrap from ptr=3, then confirm ptr=1
        step(0, 0, 4'b0100, 12'(5) << 6, 64'hBEEF << 32);
        step(0, 0, 4'b1001, 12'h6C1, 64'h1234_0000_0000_5678);
        step(0, 0, 4'b0001, 12'h002, 64'h0000_0000_0000_9ABC);
        step(0, 0, 4'b1111, 12'hFAC, 64'h1111_2222_3333_4444);
        chk("ptr_was_1", 64'(m_last_g), 64'd1);

        // Round-robin from reset
        step(1, 0, 4'b0000, 12'h0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'b1111, 12'hE4D, 64'hA0A0_B1B1_C2C2_D3D3 + 64'(i));
            chk("rr_order", 64'(m_last_g), 64'(i));
        end
        step(0, 0, 4'b0000, 12'h0, 64'h0);
        chk("rr_conflict4", 64'(bus.conflict_count), 64'd4);

        // Flush blocks the request; it wins from ptr 0 the next cycle
        step(0, 0, 4'b0100, 12'h100, 64'h0000_7777_0000_0000);
        step(0, 1, 4'b0010, 12'h038, 64'h0000_0000_4242_0000);
        step(0, 0, 4'b0010, 12'h038, 64'h0000_0000_4242_0000);
        chk("post_flush_grant", 64'(bus.grant), 64'b0010);
        step(0, 0, 4'b0000, 12'h0, 64'h0);

        // Reset in the middle of an active grant
        step(0, 0, 4'b1000, 12'h700, 64'h5555_0000_0000_0000);
        step(1, 0, 4'b1000, 12'h700, 64'h6666_0000_0000_0000);
        step(0, 0, 4'b0000, 12'h0, 64'h0);
        chk("reset_valid", 64'(bus.cdb_valid), 64'd0);

        // Randomized requesters obeying hold-until-grant
        for (int i = 0; i < N; i++) begin pend[i] = 0; waitc[i] = 0; end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(2, 0) == 0) begin
                    pend[i] = 1;
                    ptag[i] = 3'($urandom_range(7, 0));
                    pval[i] = 16'($urandom);
                end
            r = '0; tg = '0; vl = '0;
            for (int i = 0; i < N; i++) begin
                r[i] = pend[i];
                tg[i*TW +: TW] = ptag[i];
                vl[i*DW +: DW] = pval[i];
            end
            fl = ($urandom_range(19, 0) == 0);
            rs = ($urandom_range(59, 0) == 0);
            step(rs, fl, r, tg, vl);
            for (int i = 0; i < N; i++) begin
                if (rs || fl || m_last_g == i) waitc[i] = 0;
                else if (pend[i]) begin
                    waitc[i]++;
                    chk("starvation_bound", 64'(waitc[i] <= N - 1), 64'd1);
                end
            end
            if (m_last_g >= 0) pend[m_last_g] = 0;
        end

        // Saturation
        step(1, 0, 4'b0000, 12'h0, 64'h0);
        for (int c = 0; c < 65540; c++)
            step(0, 0, 4'b1111, 12'(c), {48'(c), 16'(c ^ 16'h5A5A)});
        step(0, 0, 4'b0000, 12'h0, 64'h0);
        chk("conflict_saturated", 64'(bus.conflict_count), 64'hFFFF);
        step(1, 0, 4'b1111, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 0, 4'b0000, 12'h0, 64'h0);
        chk("conflict_after_reset", 64'(bus.conflict_count), 64'd0);

        @(posedge clk); @(posedge clk); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
